// File: rtl/sram_arbiter_if.sv
// Bundle of the fetch port, MEM-stage port, stall vector and SRAM bus around sram_arbiter.
// The slave modport is the arbiter's view; master is the core/SRAM side.
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;

    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_sel;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    logic              stallreq_id;
    logic              stallreq_ex;
    logic [5:0]        stall;

    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_sel;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        input  stallreq_id, stallreq_ex, ram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, stall,
        output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        output stallreq_id, stallreq_ex, ram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, stall,
        input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Single-ported SRAM arbiter (fetch vs. MEM stage) with wait states and pipeline stall merge.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; default build gives MEM fixed priority.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 20
) (
    input logic           clk,
    input logic           rst,
    sram_arbiter_if.slave bus
);

    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StIfAcc, StMemAcc} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ram_ce_q, ram_ce_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [3:0]        ram_sel_q, ram_sel_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              mem_ready_q, mem_ready_d;

    logic if_elig, mem_elig;
    logic grant_if, grant_mem;
    logic acc_done;

    // A port's ready pulse blocks re-issue of the request it just completed.
    assign if_elig  = bus.if_req  & ~if_ready_q;
    assign mem_elig = bus.mem_req & ~mem_ready_q;
    assign acc_done = (cnt_q == 4'd0);

`ifdef SRAM_ARB_RR_EN
    logic last_grant_q;  // 0: IF granted last, 1: MEM granted last

    always_comb begin
        grant_mem = mem_elig & (~if_elig | ~last_grant_q);
        grant_if  = if_elig & ~grant_mem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b0;
        end else if ((state_q == StIdle) && (grant_mem || grant_if)) begin
            last_grant_q <= grant_mem;
        end
    end
`else
    always_comb begin
        grant_mem = mem_elig;
        grant_if  = if_elig & ~mem_elig;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant_mem) begin
                    state_d = StMemAcc;
                end else if (grant_if) begin
                    state_d = StIfAcc;
                end
            end
            StIfAcc, StMemAcc: begin
                if (acc_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        ram_ce_d    = ram_ce_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_sel_d   = ram_sel_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_mem) begin
                    cnt_d       = WaitInit;
                    ram_ce_d    = 1'b1;
                    ram_we_d    = bus.mem_we;
                    ram_addr_d  = bus.mem_addr[ADDR_W+1:2];
                    ram_sel_d   = bus.mem_sel;
                    ram_wdata_d = bus.mem_wdata;
                end else if (grant_if) begin
                    cnt_d      = WaitInit;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = bus.if_addr[ADDR_W+1:2];
                    ram_sel_d  = 4'hF;
                end
            end
            StIfAcc: begin
                if (!acc_done) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if_rdata_d = bus.ram_rdata;
                    if_ready_d = 1'b1;
                    ram_ce_d   = 1'b0;
                    ram_we_d   = 1'b0;
                end
            end
            StMemAcc: begin
                if (!acc_done) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Stores leave the load-data register untouched.
                    if (!ram_we_q) begin
                        mem_rdata_d = bus.ram_rdata;
                    end
                    mem_ready_d = 1'b1;
                    ram_ce_d    = 1'b0;
                    ram_we_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 4'd0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_sel_q   <= 4'h0;
            ram_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            if_ready_q  <= 1'b0;
            mem_rdata_q <= 32'h0;
            mem_ready_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_sel_q   <= ram_sel_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_rdata_q <= mem_rdata_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    // Release coincides with the ready cycle, so the stalled register advances on data capture.
    always_comb begin
        bus.stall = 6'b000000;
        if (!rst) begin
            if (bus.mem_req && !mem_ready_q) begin
                bus.stall = 6'b011111;
            end else if (bus.stallreq_ex) begin
                bus.stall = 6'b001111;
            end else if (bus.stallreq_id) begin
                bus.stall = 6'b000111;
            end else if (bus.if_req && !if_ready_q) begin
                bus.stall = 6'b000011;
            end
        end
    end

    assign bus.ram_ce    = ram_ce_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_sel   = ram_sel_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_ready = mem_ready_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[1:0], bus.if_addr[31:ADDR_W+2],
                                bus.mem_addr[1:0], bus.mem_addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_sram_arbiter;

    localparam int unsigned W  = 1;
    localparam int unsigned AW = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(AW)) bus ();

    sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] sram_word(input logic [AW-1:0] a);
        if (a == 20'h4) return 32'h2402_0005;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign bus.ram_rdata = sram_word(bus.ram_addr);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Transaction model: an access occupies the bus for W+1 edges after its grant edge.
    longint          edge_n = 0;
    longint          m_done = 0;
    int              m_busy = 0;  // 0 none, 1 IF, 2 MEM
    logic            m_ce, m_we;
    logic [AW-1:0]   m_addr;
    logic [3:0]      m_sel;
    logic [31:0]     m_wdata, m_if_rdata, m_mem_rdata;
    logic            m_if_ready, m_mem_ready;
    logic            m_last;  // RR only: 1 if MEM granted last

    task automatic model_reset();
        m_busy = 0; m_ce = 0; m_we = 0; m_addr = '0; m_sel = 0; m_wdata = 0;
        m_if_rdata = 0; m_mem_rdata = 0; m_if_ready = 0; m_mem_ready = 0; m_last = 0;
    endtask

    function automatic logic [5:0] exp_stall();
        if (rst) return 6'b000000;
        if (bus.mem_req && !m_mem_ready) return 6'b011111;
        if (bus.stallreq_ex) return 6'b001111;
        if (bus.stallreq_id) return 6'b000111;
        if (bus.if_req && !m_if_ready) return 6'b000011;
        return 6'b000000;
    endfunction

    task automatic model_step();
        logic e_if, e_mem, pick_mem;
        edge_n++;
        if (rst) begin
            model_reset();
            return;
        end
        e_if  = bus.if_req && !m_if_ready;
        e_mem = bus.mem_req && !m_mem_ready;
        m_if_ready  = 0;
        m_mem_ready = 0;
        if (m_busy != 0) begin
            if (edge_n == m_done) begin
                if (m_busy == 1) begin
                    m_if_rdata = sram_word(m_addr);
                    m_if_ready = 1;
                end else begin
                    if (!m_we) m_mem_rdata = sram_word(m_addr);
                    m_mem_ready = 1;
                end
                m_ce = 0; m_we = 0; m_busy = 0;
            end
        end else if (e_if || e_mem) begin
`ifdef SRAM_ARB_RR_EN
            pick_mem = (e_mem && e_if) ? !m_last : e_mem;
`else
            pick_mem = e_mem;
`endif
            m_last = pick_mem;
            m_done = edge_n + 1 + W;
            m_ce   = 1;
            if (pick_mem) begin
                m_busy = 2; m_we = bus.mem_we; m_addr = bus.mem_addr[AW+1:2];
                m_sel = bus.mem_sel; m_wdata = bus.mem_wdata;
            end else begin
                m_busy = 1; m_we = 0; m_addr = bus.if_addr[AW+1:2]; m_sel = 4'hF;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("ram_ce", bus.ram_ce, m_ce);
        check_eq("ram_we", bus.ram_we, m_we);
        check_eq("ram_addr", bus.ram_addr, m_addr);
        check_eq("ram_sel", bus.ram_sel, m_sel);
        check_eq("ram_wdata", bus.ram_wdata, m_wdata);
        check_eq("if_ready", bus.if_ready, m_if_ready);
        check_eq("if_rdata", bus.if_rdata, m_if_rdata);
        check_eq("mem_ready", bus.mem_ready, m_mem_ready);
        check_eq("mem_rdata", bus.mem_rdata, m_mem_rdata);
    endtask

    // Inputs are set at the negedge; stall is checked just after, then one clock is modelled.
    task automatic tick();
        #1;
        check_eq("stall", bus.stall, exp_stall());
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_ready(input bit is_mem, input string tag);
        logic seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (is_mem ? bus.mem_ready : bus.if_ready) begin
                seen = 1;
                break;
            end
        end
        check_eq(tag, seen, 1'b1);
    endtask

    initial begin
        model_reset();
        rst = 1;
        bus.if_req = 0; bus.if_addr = 0;
        bus.mem_req = 0; bus.mem_we = 0; bus.mem_addr = 0; bus.mem_wdata = 0; bus.mem_sel = 0;
        bus.stallreq_id = 0; bus.stallreq_ex = 0;
        tick();
        tick();
        check_eq("reset_ce", bus.ram_ce, 1'b0);
        rst = 0;

        // Single fetch
        bus.if_req = 1; bus.if_addr = 32'h0000_0010;
        tick();
        check_eq("fetch_addr", bus.ram_addr, 32'h4);
        wait_ready(0, "fetch_ready");
        check_eq("fetch_rdata", bus.if_rdata, 32'h2402_0005);
        bus.if_req = 0;
        tick();

        // Store: load-data register must stay at its reset value
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_sel = 4'b0011;
        bus.mem_addr = 32'h8; bus.mem_wdata = 32'hDEAD_BEEF;
        tick();
        check_eq("store_we", bus.ram_we, 1'b1);
        check_eq("store_sel", bus.ram_sel, 4'b0011);
        check_eq("store_addr", bus.ram_addr, 32'h2);
        wait_ready(1, "store_ready");
        check_eq("store_rdata", bus.mem_rdata, 32'h0);
        bus.mem_req = 0; bus.mem_we = 0;
        tick();

        // Contention with an ID stall request
        bus.if_req = 1; bus.if_addr = 32'h20;
        bus.mem_req = 1; bus.mem_addr = 32'h40; bus.stallreq_id = 1;
        tick();
        check_eq("cont_mem_first", bus.ram_addr, 32'h10);
        wait_ready(1, "cont_mem_ready");
        bus.mem_req = 0;
        tick();
        check_eq("cont_if_grant", bus.ram_addr, 32'h8);
        wait_ready(0, "cont_if_ready");
        bus.if_req = 0; bus.stallreq_id = 0;
        tick();

        // Held fetch request across three accesses
        bus.if_req = 1; bus.if_addr = 32'h100;
        for (int k = 0; k < 3; k++) begin
            wait_ready(0, "held_ready");
            bus.if_addr = bus.if_addr + 32'h4;
        end
        bus.if_req = 0;
        tick();

        // Reset in the middle of a load
        bus.mem_req = 1; bus.mem_addr = 32'h200;
        tick();
        rst = 1; bus.mem_req = 0;
        tick();
        check_eq("rst_mid_ce", bus.ram_ce, 1'b0);
        check_eq("rst_mid_ready", bus.mem_ready, 1'b0);
        rst = 0;
        tick();
        tick();
        check_eq("rst_mid_noready", bus.mem_ready, 1'b0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!bus.if_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.if_req = 1; bus.if_addr = $urandom;
                end
            end else if (m_if_ready) begin
                if ($urandom_range(0, 1) == 1) bus.if_req = 0;
                else bus.if_addr = $urandom;
            end
            if (!bus.mem_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.mem_req = 1; bus.mem_addr = $urandom; bus.mem_we = 1'($urandom_range(0, 1));
                    bus.mem_sel = 4'($urandom_range(0, 15)); bus.mem_wdata = $urandom;
                end
            end else if (m_mem_ready) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.mem_req = 0;
                end else begin
                    bus.mem_addr = $urandom; bus.mem_we = 1'($urandom_range(0, 1));
                    bus.mem_sel = 4'($urandom_range(0, 15)); bus.mem_wdata = $urandom;
                end
            end
            bus.stallreq_id = ($urandom_range(0, 3) == 0);
            bus.stallreq_ex = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
